// File: rtl/serializer_if.sv
// Handshake and data bundle between the command FSM (master) and the
// command-line serializer (slave).
interface serializer_if #(
  parameter int WIDTH = 136
);
  logic             enable;
  logic [WIDTH-1:0] in;
  logic [7:0]       framesize;
  logic             crc_en;
  logic             out;
  logic             busy;
  logic             complete;

  modport master (
    output enable, in, framesize, crc_en,
    input  out, busy, complete
  );

  modport slave (
    input  enable, in, framesize, crc_en,
    output out, busy, complete
  );
endinterface

// File: rtl/serializer.sv
// SD CMD-line transmitter: shifts a frame out MSB-first and optionally
// appends CRC7 plus the end bit.
module serializer #(
  parameter int WIDTH = 136
) (
  input  logic        clk,
  input  logic        reset,
  serializer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, CRC, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [7:0]       cnt, cnt_next;
  logic [6:0]       crc, crc_next;
  logic             crc_en_l, crc_en_l_next;
  logic             out_r, out_next;
  logic             busy_r, busy_next;
  logic             complete_r, complete_next;

  logic             start;
  logic [7:0]       fs_c;
  logic [7:0]       shamt;
  logic [WIDTH-1:0] aligned;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
    logic       fb;
    logic [6:0] n;
    fb   = d ^ c[6];
    n    = {c[5:0], fb};
    n[3] = n[3] ^ fb;
    return n;
  endfunction

  assign start   = (state == IDLE) && bus.enable && (bus.framesize != 8'd0);
  assign fs_c    = (bus.framesize > 8'(WIDTH)) ? 8'(WIDTH) : bus.framesize;
  assign shamt   = 8'(WIDTH) - fs_c;
  // Left-justify the frame so the first bit to send is always the register MSB.
  assign aligned = bus.in << shamt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      crc        <= '0;
      crc_en_l   <= 1'b0;
      out_r      <= 1'b1;
      busy_r     <= 1'b0;
      complete_r <= 1'b0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      cnt        <= cnt_next;
      crc        <= crc_next;
      crc_en_l   <= crc_en_l_next;
      out_r      <= out_next;
      busy_r     <= busy_next;
      complete_r <= complete_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (bus.enable && cnt == 8'd0) state_next = crc_en_l ? CRC : DONE;
      CRC:     if (bus.enable && cnt == 8'd0) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // cnt holds the number of bits still to follow the one currently on the line.
  always_comb begin
    shreg_next    = shreg;
    cnt_next      = cnt;
    crc_next      = crc;
    crc_en_l_next = crc_en_l;
    out_next      = out_r;
    busy_next     = busy_r;
    complete_next = 1'b0;
    case (state)
      IDLE: begin
        out_next  = 1'b1;
        busy_next = 1'b0;
        if (start) begin
          out_next      = aligned[WIDTH-1];
          crc_next      = crc7_step(7'd0, aligned[WIDTH-1]);
          shreg_next    = aligned << 1;
          cnt_next      = fs_c - 8'd1;
          crc_en_l_next = bus.crc_en;
          busy_next     = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.enable) begin
          if (cnt != 8'd0) begin
            out_next   = shreg[WIDTH-1];
            crc_next   = crc7_step(crc, shreg[WIDTH-1]);
            shreg_next = shreg << 1;
            cnt_next   = cnt - 8'd1;
          end else if (crc_en_l) begin
            out_next = crc[6];
            crc_next = {crc[5:0], 1'b0};
            cnt_next = 8'd7;
          end else begin
            out_next      = 1'b1;
            busy_next     = 1'b0;
            complete_next = 1'b1;
          end
        end
      end
      CRC: begin
        if (bus.enable) begin
          if (cnt != 8'd0) begin
            out_next = (cnt == 8'd1) ? 1'b1 : crc[6];
            crc_next = {crc[5:0], 1'b0};
            cnt_next = cnt - 8'd1;
          end else begin
            out_next      = 1'b1;
            busy_next     = 1'b0;
            complete_next = 1'b1;
          end
        end
      end
      default: begin
        out_next  = 1'b1;
        busy_next = 1'b0;
      end
    endcase
  end

  assign bus.out      = out_r;
  assign bus.busy     = busy_r;
  assign bus.complete = complete_r;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: expected serial bits are queued when a frame
// is issued and popped as the line is sampled.
module tb_serializer;

  localparam int WIDTH = 136;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic exp_q[$];

  serializer_if #(.WIDTH(WIDTH)) bus ();

  serializer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic push_bits(input logic [191:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  task automatic check_idle(input string tag, input logic cmpl);
    check({tag, "_out"}, bus.out, 1'b1);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_complete"}, bus.complete, cmpl);
  endtask

  // Issues one frame, walks the line against the queue, optional 2-cycle pause.
  task automatic run_frame(input logic [WIDTH-1:0] data, input logic [7:0] fs,
                           input logic ce, input int len, input int pause_at);
    logic b;
    @(negedge clk);
    bus.in        = data;
    bus.framesize = fs;
    bus.crc_en    = ce;
    bus.enable    = 1'b1;
    @(posedge clk);
    #1;
    bus.in        = ~data;
    bus.framesize = 8'd5;
    bus.crc_en    = ~ce;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL queue_underrun: observed empty expected bit %0d", k);
        b = 1'bx;
      end else begin
        b = exp_q.pop_front();
      end
      check($sformatf("bit%0d", k), bus.out, b);
      check($sformatf("busy%0d", k), bus.busy, 1'b1);
      check($sformatf("cmpl%0d", k), bus.complete, 1'b0);
      if (k == pause_at) begin
        bus.enable = 1'b0;
        for (int p = 0; p < 2; p++) begin
          @(negedge clk);
          check($sformatf("hold%0d", p), bus.out, b);
          check($sformatf("hold_busy%0d", p), bus.busy, 1'b1);
        end
        bus.enable = 1'b1;
      end
    end
    @(negedge clk);
    check_idle("done", 1'b1);
    bus.enable = 1'b0;
    @(negedge clk);
    check_idle("post", 1'b0);
    check("queue_empty", exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    logic [WIDTH-1:0] big;
    n_checks      = 0;
    n_fail        = 0;
    bus.enable    = 1'b1;
    bus.in        = '0;
    bus.in[39:0]  = 40'h40_0000_0000;
    bus.framesize = 8'd40;
    bus.crc_en    = 1'b1;
    reset         = 1'b0;

    repeat (3) @(negedge clk);
    check_idle("reset_hold", 1'b0);
    bus.enable = 1'b0;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset_release", 1'b0);

    push_bits(48'h40_0000_0000_95, 48);
    run_frame(136'h40_0000_0000, 8'd40, 1'b1, 48, -1);

    push_bits(48'h48_0000_01AA_87, 48);
    run_frame(136'h48_0000_01AA, 8'd40, 1'b1, 48, -1);

    push_bits(48'h51_0000_0000_55, 48);
    run_frame(136'h51_0000_0000, 8'd40, 1'b1, 48, -1);

    push_bits(12'hA5B, 12);
    run_frame(136'hFFF0_A5B, 8'd12, 1'b0, 12, -1);

    big = {$urandom, $urandom, $urandom, $urandom, $urandom};
    push_bits({56'd0, big}, 136);
    run_frame(big, 8'd200, 1'b0, 136, -1);

    @(negedge clk);
    bus.in        = '1;
    bus.framesize = 8'd0;
    bus.enable    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("fs_zero", 1'b0);
    end
    bus.enable = 1'b0;

    push_bits(48'h40_0000_0000_95, 48);
    run_frame(136'h40_0000_0000, 8'd40, 1'b1, 48, 9);

    // Abort CMD8 while bit 20 (a zero) is on the line.
    push_bits(48'h48_0000_01AA_87, 48);
    @(negedge clk);
    bus.in        = 136'h48_0000_01AA;
    bus.framesize = 8'd40;
    bus.crc_en    = 1'b1;
    bus.enable    = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("abort_bit%0d", k), bus.out, exp_q.pop_front());
    end
    #2;
    reset = 1'b0;
    #1;
    check_idle("abort_async", 1'b0);
    bus.enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle("abort_hold", 1'b0);
    end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_idle("abort_release", 1'b0);

    push_bits(48'h40_0000_0000_95, 48);
    run_frame(136'h40_0000_0000, 8'd40, 1'b1, 48, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
